// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter: FSM state enum,
// default frame width and a one-hot to index encoder.
package uart_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT,
        HOLD,
        DONE
    } arb_state_t;

    localparam int NB_DEFAULT = 8;
    localparam int NREQ_MAX   = 8;

    function automatic logic [2:0] onehot_to_idx(input logic [NREQ_MAX-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ_MAX; i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above the
// pointer, otherwise the first set request below it (explicit wrap).
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] winner,
    output logic [PW-1:0]   idx
);

    logic found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                winner[i] = 1'b1;
                found     = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i < int'(ptr))) begin
                winner[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign idx = PW'(onehot_to_idx(NREQ_MAX'(winner)));

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one UART byte transmitter.
// Optional watchdog on WAIT/HOLD enabled by defining UART_ARB_WDOG_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int NB      = NB_DEFAULT,
    parameter int TMO_CYC = 2000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*NB-1:0] req_data,
    input  logic [NREQ-1:0]    req_last,
    output logic [NREQ-1:0]    req_ready,
    output logic             tx_str,
    output logic [NB-1:0]    tx_data,
    input  logic             tx_fin,
    output logic [NREQ-1:0]  grant,
    output logic             busy,
    output logic             err_tmo
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t      state, state_nxt;
    logic [NREQ-1:0] pick_oh;
    logic [PW-1:0]   pick_idx;
    logic [PW-1:0]   gidx;
    logic [PW-1:0]   ptr;
    logic [NB-1:0]   tx_data_q;
    logic [NB-1:0]   owner_data;
    logic            owner_valid;
    logic            owner_last;
    logic            last_q;
    logic            expired;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req    (req_valid),
        .ptr    (ptr),
        .winner (pick_oh),
        .idx    (pick_idx)
    );

    always_comb begin
        owner_data  = '0;
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gidx == PW'(i)) begin
                owner_data  = req_data[i*NB +: NB];
                owner_valid = req_valid[i];
                owner_last  = req_last[i];
            end
        end
    end

    // tx_data is live during the strobe, then held from the register
    assign tx_str    = (state == SEND);
    assign req_ready = tx_str ? grant : '0;
    assign tx_data   = tx_str ? owner_data : tx_data_q;

`ifdef UART_ARB_WDOG_EN
    localparam int CW = $clog2(TMO_CYC + 1);

    logic [CW-1:0] wd_cnt;
    logic          in_wait;

    assign in_wait = (state == WAIT) || (state == HOLD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (((state_nxt == WAIT) || (state_nxt == HOLD)) && (state_nxt != state)) begin
            wd_cnt <= CW'(TMO_CYC);
        end else if (in_wait && (wd_cnt != '0)) begin
            wd_cnt <= wd_cnt - CW'(1);
        end
    end

    assign expired = in_wait && (wd_cnt == '0);
`else
    assign expired = 1'b0;
`endif

    // Completing events (fin, owner resuming) take precedence over expiry
    always_comb begin
        state_nxt = state;
        err_tmo   = 1'b0;
        case (state)
            IDLE: if (|req_valid) state_nxt = SEND;
            SEND: state_nxt = WAIT;
            WAIT: begin
                if (tx_fin) begin
                    if (last_q)           state_nxt = DONE;
                    else if (owner_valid) state_nxt = SEND;
                    else                  state_nxt = HOLD;
                end else if (expired) begin
                    state_nxt = DONE;
                    err_tmo   = 1'b1;
                end
            end
            HOLD: begin
                if (owner_valid) begin
                    state_nxt = SEND;
                end else if (expired) begin
                    state_nxt = DONE;
                    err_tmo   = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            gidx      <= '0;
            ptr       <= '0;
            busy      <= 1'b0;
            tx_data_q <= '0;
            last_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant <= pick_oh;
                        gidx  <= pick_idx;
                        busy  <= 1'b1;
                    end
                end
                SEND: begin
                    tx_data_q <= owner_data;
                    last_q    <= owner_last;
                end
                DONE: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    ptr   <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART byte transmitter (start-strobe in, finish-pulse out) between NREQ message sources, e.g. the NMEA echo path, the status reporter and the debug dump.
- Arbitration is round-robin at message granularity. Once granted, a requester owns the transmitter until its byte marked last has been fully sent.
- The block sequences the transmitter byte by byte. It never issues a new start before the previous frame's finish pulse.

Parameters:
- NREQ, 4, number of requesters (1..8).
- NB, 8, data bits per UART frame.
- TMO_CYC, 2000000, watchdog limit in clk cycles (used only with UART_ARB_WDOG_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  requester i has a byte on req_data slice i.
- req_data  in  NREQ*NB  packed bytes; slice i is [i*NB +: NB].
- req_last  in  NREQ  byte on slice i is the last byte of its message.
- req_ready  out  NREQ  one-hot; byte on slice i is accepted this cycle.
- tx_str  out  1  one-cycle start strobe to the transmitter.
- tx_data  out  NB  byte for the transmitter; valid while tx_str=1 and held afterwards.
- tx_fin  in  1  one-cycle pulse from the transmitter at the end of the stop bit.
- grant  out  NREQ  one-hot current owner; all zero when idle.
- busy  out  1  a message is in progress.
- err_tmo  out  1  watchdog expiry pulse (tied 0 without the macro).

Behaviour:
- Reset values: state IDLE, grant=0, busy=0, tx_str=0, tx_data=0, req_ready=0, err_tmo=0, priority pointer=0, last_q=0.
- States:
  - IDLE: if any req_valid is set, register the winner into grant, set busy=1, go to SEND. Otherwise stay in IDLE.
  - SEND: lasts exactly one cycle. tx_str=1, req_ready[g]=1, tx_data<=req_data slice g, last_q<=req_last[g]. Go to WAIT.
  - WAIT: on tx_fin, if last_q=1 go to DONE. If last_q=0 and req_valid[g]=1, go to SEND. If last_q=0 and req_valid[g]=0, go to HOLD.
  - HOLD: the owner keeps the grant. When req_valid[g]=1, go to SEND. Other requesters cannot preempt.
  - DONE: lasts one cycle. Pointer <= (g+1) mod NREQ, grant=0, busy=0, go to IDLE.
- Arbitration: the first requester with valid set, scanning from the pointer upward with wrap-around. After reset, requester 0 has the highest priority.
- Latency:
  - req_valid rising in IDLE at cycle 0: grant at cycle 1, tx_str at cycle 1, first byte accepted at cycle 1.
  - tx_fin at cycle n: next tx_str at cycle n+1 when data is ready.
- Each byte has exactly one req_ready pulse. req_ready and tx_str are derived only from state==SEND, never combinationally from req_valid.
- tx_fin outside WAIT is ignored; the transmitter is assumed to issue at most one fin per str.
- req_valid from non-owners is ignored while busy. Their data is not consumed.
- A single-byte message (last=1 on the first byte) takes the path IDLE→SEND→WAIT→DONE.
- With NREQ=1, the pointer stays 0 and the block behaves as a plain sequencer.
- rst asserted mid-frame: immediately return to reset values. The transmitter is reset by the same rst, so no frame is half-owned.
- Width rule: the pointer is $clog2(NREQ) bits, minimum 1. The wrap is computed explicitly and does not rely on power-of-two NREQ.

Optional Feature:
- Macro: UART_ARB_WDOG_EN.
- With the macro defined:
  - A counter loads TMO_CYC on entry to WAIT or HOLD and decrements each cycle spent there.
  - If it reaches 0 before leaving WAIT or HOLD, err_tmo pulses for 1 cycle and the block goes to DONE. The grant is released and the pointer advances.
  - A tx_fin in the same cycle as expiry takes precedence; no error is raised.
- Without the macro: no counter is built, err_tmo is constant 0, and WAIT/HOLD can last forever.

Decomposition:
- Package uart_arb_pkg holds:
  - the state enum typedef (IDLE, SEND, WAIT, HOLD, DONE);
  - the NB default;
  - a function for one-hot-to-index conversion.
- Sub-module rr_pick (pure combinational): inputs req vector and pointer; output one-hot winner plus index. It is instantiated once.

Test Plan:
- Single requester: req0 sends "$GP" with last on 'P'; the transmitter model gives fin 10 cycles after each str → exactly 3 tx_str with tx_data 0x24, 0x47, 0x50, then grant returns to 0. busy stays high from the first grant until DONE, and the pointer ends at 1.
- Contention: after reset, req1 and req2 both hold 2-byte messages → req1 is served first, then req2, and the bytes are never interleaved. A new req1 request arriving during req2's message waits until req2's DONE.
- Round-robin fairness: all 4 requesters continuously valid with 1-byte messages → grant order is 0,1,2,3,0,1 and each gets exactly one byte per round.
- HOLD: req0 drops valid after its first byte (last=0) while req1 is valid → tx_str stays 0 and grant stays 0001. When req0 resumes, its next byte is sent before req1.
- Reset mid-message: assert rst 3 cycles after the second tx_str → all outputs are 0 the same cycle. After release, req0 wins again with pointer 0.
- Watchdog (macro on, TMO_CYC=50): withhold tx_fin → err_tmo pulses exactly 50 cycles after entering WAIT, grant releases, and the next requester is granted.
